// File: rtl/low_power_pkg.sv
// low_power_pkg: PIO register offsets and state encodings shared by the low-power sequencer.
package low_power_pkg;
    localparam logic [1:0] LP_DATA_OFS = 2'd0;
    localparam logic [1:0] LP_EDGE_OFS = 2'd3;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        LOWPWR = 2'd2
    } pwr_state_e;
    typedef enum logic [2:0] {
        P_IDLE,
        P_RD_EDGE,
        P_CHK_EDGE,
        P_CLR_EDGE,
        P_RD_DATA,
        P_CHK_DATA
    } poll_state_e;
endpackage

// File: rtl/low_power_state_fsm.sv
// low_power_state_fsm: filters polled low-power levels into RUN/DRAIN/LOWPWR with grace and recovery counts.
module low_power_state_fsm
    import low_power_pkg::*;
#(
    parameter int GRACE_POLLS   = 16,
    parameter int RECOVER_POLLS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_i,
    input  logic       level_i,
    output logic       servo_en_o,
    output logic       lp_irq_o,
    output logic [1:0] power_state_o
);
    localparam int GW = $clog2(GRACE_POLLS + 1);
    localparam int RW = $clog2(RECOVER_POLLS + 1);

    pwr_state_e     state_q, state_d;
    logic [GW-1:0]  grace_q, grace_d;
    logic [RW-1:0]  recover_q, recover_d;
    logic           lp_irq_q, lp_irq_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            grace_q   <= '0;
            recover_q <= '0;
            lp_irq_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grace_q   <= grace_d;
            recover_q <= recover_d;
            lp_irq_q  <= lp_irq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grace_d   = grace_q;
        recover_d = recover_q;
        if (sample_i) begin
            case (state_q)
                RUN: begin
                    if (level_i) begin
                        grace_d = GW'(1);
                        state_d = (GRACE_POLLS == 1) ? LOWPWR : DRAIN;
                    end
                end
                DRAIN: begin
                    grace_d = level_i ? grace_q + 1'b1 : '0;
                    state_d = !level_i ? RUN :
                              (grace_q + 1'b1 == GW'(GRACE_POLLS)) ? LOWPWR : DRAIN;
                end
                LOWPWR: begin
                    recover_d = level_i ? '0 : recover_q + 1'b1;
                    state_d   = (!level_i && recover_q + 1'b1 == RW'(RECOVER_POLLS)) ? RUN : LOWPWR;
                end
                default: state_d = RUN;
            endcase
        end
        lp_irq_d = state_d == LOWPWR && state_q != LOWPWR;
        // Counters start fresh on every LOWPWR entry and exit.
        if (state_d != state_q && (state_d == LOWPWR || state_q == LOWPWR)) begin
            grace_d   = '0;
            recover_d = '0;
        end
    end

    assign servo_en_o    = state_q != LOWPWR;
    assign lp_irq_o      = lp_irq_q;
    assign power_state_o = state_q;
endmodule

// File: rtl/low_power_pio_sequencer.sv
// low_power_pio_sequencer: Avalon-MM master that polls the low-power PIO, counts/clears edges and gates servo power.
module low_power_pio_sequencer
    import low_power_pkg::*;
#(
    parameter int POLL_INTERVAL = 1000,
    parameter int GRACE_POLLS   = 16,
    parameter int RECOVER_POLLS = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             poll_en,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             servo_en,
    output logic             lp_irq,
    output logic [1:0]       power_state,
    output logic [CNT_W-1:0] edge_count
);
    localparam int TW = $clog2(POLL_INTERVAL);

    poll_state_e      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample;
    logic             unused_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= P_IDLE;
            timer_q <= TW'(POLL_INTERVAL - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        case (state_q)
            P_IDLE: begin
                state_d = (poll_en && timer_q == '0) ? P_RD_EDGE : P_IDLE;
                timer_d = (poll_en && timer_q != '0) ? timer_q - 1'b1 : timer_q;
            end
            P_RD_EDGE:  state_d = P_CHK_EDGE;
            P_CHK_EDGE: begin
                state_d = avm_readdata[0] ? P_CLR_EDGE : P_RD_DATA;
                cnt_d   = (avm_readdata[0] && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
            end
            P_CLR_EDGE: state_d = P_RD_DATA;
            P_RD_DATA:  state_d = P_CHK_DATA;
            P_CHK_DATA: begin
                state_d = P_IDLE;
                timer_d = TW'(POLL_INTERVAL - 1);
            end
            default: state_d = P_IDLE;
        endcase
    end

    // Bus strobes decode straight from the registered state, so reset drops them at once.
    assign avm_chipselect = state_q inside {P_RD_EDGE, P_CLR_EDGE, P_RD_DATA};
    assign avm_address    = (state_q == P_RD_EDGE || state_q == P_CLR_EDGE) ? LP_EDGE_OFS : LP_DATA_OFS;
    assign avm_write_n    = state_q != P_CLR_EDGE;
    assign avm_writedata  = {31'd0, state_q == P_CLR_EDGE};
    assign sample         = state_q == P_CHK_DATA;
    assign edge_count     = cnt_q;
    assign unused_rd      = ^avm_readdata[31:1];

    low_power_state_fsm #(
        .GRACE_POLLS   (GRACE_POLLS),
        .RECOVER_POLLS (RECOVER_POLLS)
    ) u_state (
        .clk           (clk),
        .reset         (reset),
        .sample_i      (sample),
        .level_i       (avm_readdata[0]),
        .servo_en_o    (servo_en),
        .lp_irq_o      (lp_irq),
        .power_state_o (power_state)
    );
endmodule

// File: tb/tb_low_power_pio_sequencer.sv
// tb_low_power_pio_sequencer: directed bench with a behavioural low-power PIO slave.
module tb_low_power_pio_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        poll_en = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        servo_en, lp_irq;
    logic [1:0]  power_state;
    logic [3:0]  edge_count;

    logic in_port = 1'b0, prev_in = 1'b0, cap = 1'b0;
    int   n_chk = 0, n_err = 0;
    int   cyc = 0, t_rde = 0, period = 0, gap_data = 0;
    int   n_wr = 0, bad_wr = 0, seq_err = 0, n_irq = 0, n_cs = 0;
    logic [1:0] last_rd = 2'd0;
    bit   ok;
    int   cs0;

    low_power_pio_sequencer #(
        .POLL_INTERVAL (8),
        .GRACE_POLLS   (3),
        .RECOVER_POLLS (2),
        .CNT_W         (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .poll_en        (poll_en),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .servo_en       (servo_en),
        .lp_irq         (lp_irq),
        .power_state    (power_state),
        .edge_count     (edge_count)
    );

    always #5 clk = ~clk;

    // PIO slave: registered read data, rising-edge capture, a clear write beats a same-cycle edge.
    always @(posedge clk) begin
        prev_in <= in_port;
        avm_readdata <= {31'd0, avm_address == 2'd3 ? cap : in_port};
        if (avm_chipselect && !avm_write_n && avm_address == 2'd3 && avm_writedata[0]) cap <= 1'b0;
        else if (in_port && !prev_in) cap <= 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (reset) last_rd = 2'd0;
        else if (avm_chipselect) begin
            n_cs++;
            if (!avm_write_n) begin
                n_wr++;
                if (avm_address != 2'd3 || avm_writedata != 32'h1) bad_wr++;
            end else begin
                if (avm_address == last_rd || (avm_address != 2'd0 && avm_address != 2'd3)) seq_err++;
                last_rd = avm_address;
                if (avm_address == 2'd3) begin
                    period = cyc - t_rde;
                    t_rde  = cyc;
                end else gap_data = cyc - t_rde;
            end
        end
        if (lp_irq) n_irq++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_poll();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (avm_chipselect && avm_write_n && avm_address == 2'd0) seen = 1;
        end
        chk("poll_done", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic poll_expect(input string tag, input logic [1:0] ps, input logic se);
        run_poll();
        chk({tag, "_ps"}, 32'(power_state), 32'(ps));
        chk({tag, "_servo"}, 32'(servo_en), 32'(se));
    endtask

    initial begin
        @(negedge clk);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_wn", 32'(avm_write_n), 32'd1);
        chk("rst_wd", avm_writedata, 32'd0);
        chk("rst_servo", 32'(servo_en), 32'd1);
        chk("rst_irq", 32'(lp_irq), 32'd0);
        chk("rst_ps", 32'(power_state), 32'd0);
        chk("rst_cnt", 32'(edge_count), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle_cs", 32'(n_cs), 32'd6);
        chk("idle_wr", 32'(n_wr), 32'd0);
        chk("idle_period", 32'(period), 32'd12);
        chk("idle_gap", 32'(gap_data), 32'd2);
        chk("idle_ps", 32'(power_state), 32'd0);
        chk("idle_cnt", 32'(edge_count), 32'd0);

        in_port = 1'b1;
        poll_expect("drain1", 2'd1, 1'b1);
        chk("drain1_cnt", 32'(edge_count), 32'd1);
        chk("drain1_gap", 32'(gap_data), 32'd3);
        chk("drain1_wr", 32'(n_wr), 32'd1);
        poll_expect("drain2", 2'd1, 1'b1);
        in_port = 1'b0;
        poll_expect("back_run", 2'd0, 1'b1);
        chk("back_run_irq", 32'(n_irq), 32'd0);
        chk("back_run_wr", 32'(n_wr), 32'd1);

        in_port = 1'b1;
        poll_expect("lp1", 2'd1, 1'b1);
        chk("lp1_cnt", 32'(edge_count), 32'd2);
        poll_expect("lp2", 2'd1, 1'b1);
        chk("lp2_irq", 32'(n_irq), 32'd0);
        poll_expect("lp3", 2'd2, 1'b0);
        chk("lp3_irq_now", 32'(lp_irq), 32'd1);
        poll_expect("lp4", 2'd2, 1'b0);
        chk("lp4_irq", 32'(n_irq), 32'd1);
        chk("lp4_wr", 32'(n_wr), 32'd2);

        in_port = 1'b0;
        poll_expect("rec1", 2'd2, 1'b0);
        in_port = 1'b1;
        poll_expect("rec2", 2'd2, 1'b0);
        chk("rec2_cnt", 32'(edge_count), 32'd3);
        in_port = 1'b0;
        poll_expect("rec3", 2'd2, 1'b0);
        poll_expect("rec4", 2'd0, 1'b1);
        chk("rec4_irq", 32'(n_irq), 32'd1);

        for (int i = 0; i < 20; i++) begin
            in_port = 1'b1;
            @(negedge clk);
            in_port = 1'b0;
            run_poll();
            if (i == 10) chk("sat_pre", 32'(edge_count), 32'd14);
        end
        chk("sat_cnt", 32'(edge_count), 32'd15);
        chk("sat_wr", 32'(n_wr), 32'd23);
        chk("sat_ps", 32'(power_state), 32'd0);
        chk("bad_wr", 32'(bad_wr), 32'd0);
        chk("seq_err", 32'(seq_err), 32'd0);

        in_port = 1'b1;
        @(negedge clk);
        in_port = 1'b0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n) ok = 1;
        end
        chk("clr_seen", 32'(ok), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_cs", 32'(avm_chipselect), 32'd0);
        chk("arst_wn", 32'(avm_write_n), 32'd1);
        chk("arst_addr", 32'(avm_address), 32'd0);
        chk("arst_wd", avm_writedata, 32'd0);
        chk("arst_cnt", 32'(edge_count), 32'd0);
        chk("arst_servo", 32'(servo_en), 32'd1);
        chk("arst_ps", 32'(power_state), 32'd0);
        chk("arst_irq", 32'(lp_irq), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (avm_chipselect && avm_write_n && avm_address == 2'd3) ok = 1;
        end
        chk("pe_rde", 32'(ok), 32'd1);
        poll_en = 1'b0;
        run_poll();
        chk("pe_cnt", 32'(edge_count), 32'd1);
        cs0 = n_cs;
        repeat (30) @(negedge clk);
        chk("pe_quiet", 32'(n_cs - cs0), 32'd0);
        poll_en = 1'b1;
        run_poll();
        chk("pe_resume", 32'(n_cs - cs0), 32'd2);
        chk("seq_err_end", 32'(seq_err), 32'd0);
        chk("bad_wr_end", 32'(bad_wr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/low_power_pio_sequencer.md
Name: low_power_pio_sequencer

Overview:
- Avalon-MM master that owns the low-power input PIO (one-bit level on address 0, edge-capture on address 3, write bit0=1 to clear).
- Periodically polls that PIO, counts and clears captured rising edges, and filters the level into a power state: RUN, DRAIN, LOWPWR.
- Drives the global servo-enable line and a low-power interrupt to the HPS.
- Sits in soc_system between the interconnect-free PIO slave port and the servo PWM bank.

Parameters:
- POLL_INTERVAL, 1000, clock cycles from the end of one poll to the start of the next (>=2).
- GRACE_POLLS, 16, consecutive level=1 polls in DRAIN before entering LOWPWR (>=1).
- RECOVER_POLLS, 4, consecutive level=0 polls in LOWPWR before returning to RUN (>=1).
- CNT_W, 16, width of the saturating edge event counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- poll_en  in  1  1 = polling enabled; 0 = finish the current poll, then hold in IDLE
- avm_address  out  2  PIO register offset
- avm_chipselect  out  1  PIO chip select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  32  PIO write data
- avm_readdata  in  32  PIO read data; registered by the slave, valid 1 cycle after address
- servo_en  out  1  1 = servos powered
- lp_irq  out  1  one-cycle pulse on entry to LOWPWR
- power_state  out  2  0=RUN, 1=DRAIN, 2=LOWPWR
- edge_count  out  CNT_W  saturating count of captured edges

Behaviour:
- Reset values (asynchronous):
  - avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0.
  - servo_en=1, lp_irq=0, power_state=RUN, edge_count=0.
  - Poll FSM=IDLE, timer=POLL_INTERVAL-1, grace and recover counters=0.
  - Reset mid-transaction aborts the poll. No write is ever left asserted.
- Poll FSM, one state per cycle except IDLE:
  - IDLE: chipselect=0. Timer decrements while poll_en=1 and holds while poll_en=0. At timer==0 with poll_en=1, go to RD_EDGE.
  - RD_EDGE: address=3, chipselect=1, write_n=1.
  - CHK_EDGE: sample avm_readdata[0]. If 1, increment edge_count (saturate at all-ones) and go to CLR_EDGE; otherwise go to RD_DATA.
  - CLR_EDGE: address=3, chipselect=1, write_n=0, writedata=32'h1, for exactly one cycle.
  - RD_DATA: address=0, chipselect=1, write_n=1.
  - CHK_DATA: sample avm_readdata[0] as the level, update the power FSM, reload timer=POLL_INTERVAL-1, go to IDLE.
  - Poll length is 4 cycles without an edge and 5 with one.
  - poll_en falling mid-poll does not abort; the poll completes.
- Power FSM, updated only in CHK_DATA:
  - RUN: level=1 sets grace=1 and enters DRAIN. If GRACE_POLLS==1, go directly to LOWPWR.
  - DRAIN: level=0 returns to RUN and clears grace. level=1 increments grace; when grace reaches GRACE_POLLS, enter LOWPWR.
  - LOWPWR: servo_en=0. level=0 increments recover; when recover reaches RECOVER_POLLS, return to RUN with servo_en=1. level=1 clears recover.
  - lp_irq is high for the single cycle following the CHK_DATA that enters LOWPWR.
  - servo_en changes in that same cycle.
- Boundary conditions:
  - Edge seen with level=0 (glitch): edge_count increments and power state is unchanged.
  - An edge arriving in the same cycle as CLR_EDGE is lost in the PIO. This is accepted; the level read in the same poll still captures the condition.
  - edge_count holds at saturation.
  - The FSM never issues chipselect on two addresses in the same cycle.

Decomposition:
- Package low_power_pkg holds:
  - PIO offsets: LP_DATA_OFS=0, LP_EDGE_OFS=3.
  - Power state encodings: RUN, DRAIN, LOWPWR.
  - Poll state encoding.
- One natural sub-module, low_power_state_fsm, holds the power FSM with its grace/recover counters.
  - Inputs: sample strobe and level.
  - Outputs: servo_en, lp_irq, power_state.
- The poll FSM, timer and edge counter stay in the top level.

Test Plan (POLL_INTERVAL=8, GRACE_POLLS=3, RECOVER_POLLS=2, CNT_W=4, bench uses a behavioural PIO model):
- Reset, in_port=0, run 40 cycles -> poll cycles of 4, addresses sequence 3,0 each poll, no writes, power_state=0, servo_en=1, edge_count=0.
- in_port 0->1 held -> next poll writes 1 to address 3 once, edge_count=1. Third consecutive level=1 poll gives power_state=2, servo_en=0, single lp_irq pulse. power_state=1 on the polls before that.
- in_port high for 2 polls then low -> DRAIN then RUN, lp_irq never asserted, servo_en stays 1.
- From LOWPWR, in_port 0,1,0,0 across polls -> recover resets on the 1, RUN only after the 4th poll, servo_en=1.
- 20 single-cycle pulses on in_port, one per poll -> edge_count saturates at 4'hF, each pulse cleared by exactly one write.
- Assert reset during CLR_EDGE; separately drop poll_en mid-poll -> on reset, chipselect=0 and write_n=1 immediately and all outputs at reset values. On poll_en drop, the poll completes, then no chipselect until poll_en=1.
